// File: rtl/move_source_arbiter.sv
// Picks the move source by turn, range-checks the move, issues it to the game FSM
// as a one-cycle strobe and reports whether it was accepted, rejected or timed out.
module move_source_arbiter #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         BOARD_SIZE     = 9,
    parameter logic [7:0] PASS_CODE      = 8'hFF
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       my_color,
    input  logic       turn,
    input  logic       invalid_move,
    input  logic       game_over,
    input  logic       local_valid,
    input  logic [7:0] local_move,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] move,
    output logic       move_avail,
    output logic       busy,
    output logic       move_accepted,
    output logic       move_rejected,
    output logic       move_timeout,
    output logic       range_err,
    output logic       wrong_src
);

    localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      BOARD_LIM  = 5'(BOARD_SIZE);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [7:0]    move_q, move_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          turn_at_issue_q, turn_at_issue_d;
    logic          move_avail_q, move_avail_d;
    logic          busy_q, busy_d;
    logic          accepted_q, accepted_d;
    logic          rejected_q, rejected_d;
    logic          timeout_q, timeout_d;
    logic          range_err_q, range_err_d;
    logic          wrong_src_q, wrong_src_d;

    logic          sel_local, sel_valid, other_valid;
    logic [7:0]    sel_byte;

    function automatic logic is_legal(input logic [7:0] m);
        return (m == PASS_CODE) ||
               (({1'b0, m[7:4]} < BOARD_LIM) && ({1'b0, m[3:0]} < BOARD_LIM));
    endfunction

    assign sel_local   = (turn == my_color);
    assign sel_valid   = sel_local ? local_valid : rx_valid;
    assign sel_byte    = sel_local ? local_move  : rx_byte;
    assign other_valid = sel_local ? rx_valid    : local_valid;

    always_comb begin
        state_d         = state_q;
        move_d          = move_q;
        timer_d         = timer_q;
        turn_at_issue_d = turn_at_issue_q;
        accepted_d      = 1'b0;
        rejected_d      = 1'b0;
        timeout_d       = 1'b0;
        range_err_d     = 1'b0;
        wrong_src_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    if (is_legal(sel_byte)) begin
                        move_d  = sel_byte;
                        state_d = ISSUE;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
                wrong_src_d = other_valid;
            end
            ISSUE: begin
                turn_at_issue_d = turn;
                timer_d         = '0;
                state_d         = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                timer_d = timer_q + TW'(1);
                if (invalid_move) begin
                    rejected_d = 1'b1;
                    state_d    = IDLE;
                end else if (turn != turn_at_issue_q) begin
                    accepted_d = 1'b1;
                    state_d    = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of game wins over everything, including a move latched this cycle.
        if (game_over) begin
            state_d     = LOCKED;
            move_d      = move_q;
            accepted_d  = 1'b0;
            rejected_d  = 1'b0;
            timeout_d   = 1'b0;
            range_err_d = 1'b0;
            wrong_src_d = 1'b0;
        end

        move_avail_d = (state_d == ISSUE);
        busy_d       = (state_d == ISSUE) || (state_d == WAIT_RESULT);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q         <= IDLE;
            move_q          <= 8'h00;
            timer_q         <= '0;
            turn_at_issue_q <= 1'b0;
            move_avail_q    <= 1'b0;
            busy_q          <= 1'b0;
            accepted_q      <= 1'b0;
            rejected_q      <= 1'b0;
            timeout_q       <= 1'b0;
            range_err_q     <= 1'b0;
            wrong_src_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            move_q          <= move_d;
            timer_q         <= timer_d;
            turn_at_issue_q <= turn_at_issue_d;
            move_avail_q    <= move_avail_d;
            busy_q          <= busy_d;
            accepted_q      <= accepted_d;
            rejected_q      <= rejected_d;
            timeout_q       <= timeout_d;
            range_err_q     <= range_err_d;
            wrong_src_q     <= wrong_src_d;
        end
    end

    assign move          = move_q;
    assign move_avail    = move_avail_q;
    assign busy          = busy_q;
    assign move_accepted = accepted_q;
    assign move_rejected = rejected_q;
    assign move_timeout  = timeout_q;
    assign range_err     = range_err_q;
    assign wrong_src     = wrong_src_q;

endmodule

// File: tb/tb_move_source_arbiter.sv
// Scenario-per-task bench for move_source_arbiter; expected results come from a
// transaction-level model of the move rules (legality, source choice, cycle offsets).
module tb_move_source_arbiter;

    localparam int TO = 16;

    localparam logic [6:0] F_AVAIL = 7'b1000000;
    localparam logic [6:0] F_BUSY  = 7'b0100000;
    localparam logic [6:0] F_ACC   = 7'b0010000;
    localparam logic [6:0] F_REJ   = 7'b0001000;
    localparam logic [6:0] F_TO    = 7'b0000100;
    localparam logic [6:0] F_RERR  = 7'b0000010;
    localparam logic [6:0] F_WSRC  = 7'b0000001;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       my_color = 1'b0, turn = 1'b0, invalid_move = 1'b0, game_over = 1'b0;
    logic       local_valid = 1'b0, rx_valid = 1'b0;
    logic [7:0] local_move = 8'h00, rx_byte = 8'h00;
    logic [7:0] move;
    logic       move_avail, busy, move_accepted, move_rejected, move_timeout, range_err, wrong_src;
    logic [6:0] flags;
    logic [7:0] exp_move;

    int vectors = 0;
    int miscompares = 0;

    move_source_arbiter #(.TIMEOUT_CYCLES(TO), .BOARD_SIZE(9), .PASS_CODE(8'hFF)) dut (
        .clk_in(clk_in), .reset(reset), .my_color(my_color), .turn(turn),
        .invalid_move(invalid_move), .game_over(game_over),
        .local_valid(local_valid), .local_move(local_move),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .move(move), .move_avail(move_avail), .busy(busy),
        .move_accepted(move_accepted), .move_rejected(move_rejected),
        .move_timeout(move_timeout), .range_err(range_err), .wrong_src(wrong_src)
    );

    assign flags = {move_avail, busy, move_accepted, move_rejected, move_timeout, range_err, wrong_src};

    always #5 clk_in = ~clk_in;

    // Model: a move is legal if it is a pass or both nibbles index inside a 9x9 board.
    function automatic bit model_legal(input logic [7:0] m);
        int r, c;
        r = int'(m) / 16;
        c = int'(m) % 16;
        return (m == 8'hFF) || (r < 9 && c < 9);
    endfunction

    function automatic logic [7:0] rand_legal();
        if ($urandom_range(0, 4) == 0) return 8'hFF;
        return 8'(16 * $urandom_range(0, 8) + $urandom_range(0, 8));
    endfunction

    function automatic logic [7:0] rand_illegal();
        logic [7:0] m;
        m = 8'($urandom);
        while (model_legal(m)) m = 8'($urandom);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one strobe cycle; on return the bench sits in the following cycle.
    task automatic strobe(input bit lv, input bit rv, input logic [7:0] lm, input logic [7:0] rb);
        local_valid = lv;
        local_move  = lm;
        rx_valid    = rv;
        rx_byte     = rb;
        tick();
        local_valid = 1'b0;
        rx_valid    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        local_valid = 1'b1;
        local_move = 8'h11;
        tick();
        tick();
        vectors++;
        if (flags !== 7'd0 || move !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_hold flags=%b move=%h required flags=0000000 move=00", flags, move);
        end
        local_valid = 1'b0;
        reset = 1'b0;
        tick();
        vectors++;
        if (flags !== 7'd0 || move !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release flags=%b move=%h required flags=0000000 move=00", flags, move);
        end
        exp_move = 8'h00;
    endtask

    task automatic test_accept();
        logic [7:0] m;
        bit loc;
        int d;
        for (int it = 0; it < 12; it++) begin
            if (it == 0) begin
                turn = 1'b0; my_color = 1'b0; m = 8'h34; d = 2;
            end else begin
                turn = 1'($urandom); my_color = 1'($urandom);
                m = rand_legal(); d = $urandom_range(0, 12);
            end
            loc = (turn == my_color);
            strobe(loc, !loc, loc ? m : 8'h00, loc ? 8'h00 : m);
            exp_move = m;
            vectors++;
            if (flags !== (F_AVAIL | F_BUSY) || move !== exp_move) begin
                miscompares++;
                $display("FAIL accept_issue it=%0d flags=%b move=%h required flags=%b move=%h",
                         it, flags, move, F_AVAIL | F_BUSY, exp_move);
            end
            for (int k = 0; k <= d; k++) begin
                tick();
                vectors++;
                if (flags !== F_BUSY || move !== exp_move) begin
                    miscompares++;
                    $display("FAIL accept_wait it=%0d k=%0d flags=%b move=%h required flags=%b move=%h",
                             it, k, flags, move, F_BUSY, exp_move);
                end
            end
            turn = ~turn;
            tick();
            vectors++;
            if (flags !== F_ACC) begin
                miscompares++;
                $display("FAIL accept_pulse it=%0d flags=%b required %b", it, flags, F_ACC);
            end
            tick();
            vectors++;
            if (flags !== 7'd0) begin
                miscompares++;
                $display("FAIL accept_idle it=%0d flags=%b required 0000000", it, flags);
            end
        end
    endtask

    task automatic test_wrong_src();
        logic [7:0] other;
        bit loc;
        my_color = 1'b0; turn = 1'b1;
        strobe(1'b1, 1'b1, 8'h22, 8'hFF);
        exp_move = 8'hFF;
        vectors++;
        if (flags !== (F_AVAIL | F_BUSY | F_WSRC) || move !== 8'hFF) begin
            miscompares++;
            $display("FAIL both_strobe flags=%b move=%h required flags=%b move=ff",
                     flags, move, F_AVAIL | F_BUSY | F_WSRC);
        end
        tick();
        invalid_move = 1'b1;
        tick();
        invalid_move = 1'b0;
        vectors++;
        if (flags !== F_REJ) begin
            miscompares++;
            $display("FAIL both_strobe_reject flags=%b required %b", flags, F_REJ);
        end
        for (int it = 0; it < 8; it++) begin
            turn = 1'($urandom); my_color = 1'($urandom);
            loc = (turn == my_color);
            other = rand_legal();
            strobe(!loc, loc, other, other);
            vectors++;
            if (flags !== F_WSRC || move !== exp_move) begin
                miscompares++;
                $display("FAIL wrong_src it=%0d flags=%b move=%h required flags=%b move=%h",
                         it, flags, move, F_WSRC, exp_move);
            end
            other = rand_illegal();
            strobe(1'b1, 1'b1, other, other);
            vectors++;
            if (flags !== (F_RERR | F_WSRC) || move !== exp_move) begin
                miscompares++;
                $display("FAIL both_illegal it=%0d flags=%b move=%h required flags=%b move=%h",
                         it, flags, move, F_RERR | F_WSRC, exp_move);
            end
        end
    endtask

    task automatic test_range();
        logic [7:0] m;
        bit loc;
        my_color = 1'b0; turn = 1'b0;
        strobe(1'b1, 1'b0, 8'h29, 8'h00);
        vectors++;
        if (flags !== F_RERR || move !== exp_move) begin
            miscompares++;
            $display("FAIL range_29 flags=%b move=%h required flags=%b move=%h", flags, move, F_RERR, exp_move);
        end
        for (int it = 0; it < 8; it++) begin
            turn = 1'($urandom); my_color = 1'($urandom);
            loc = (turn == my_color);
            m = rand_illegal();
            strobe(loc, !loc, m, m);
            vectors++;
            if (flags !== F_RERR || move !== exp_move) begin
                miscompares++;
                $display("FAIL range_rand it=%0d m=%h flags=%b move=%h required flags=%b move=%h",
                         it, m, flags, move, F_RERR, exp_move);
            end
        end
        my_color = 1'b0; turn = 1'b0;
        strobe(1'b1, 1'b0, 8'h88, 8'h00);
        exp_move = 8'h88;
        vectors++;
        if (flags !== (F_AVAIL | F_BUSY) || move !== 8'h88) begin
            miscompares++;
            $display("FAIL range_88 flags=%b move=%h required flags=%b move=88", flags, move, F_AVAIL | F_BUSY);
        end
        tick();
        invalid_move = 1'b1;
        tick();
        invalid_move = 1'b0;
        vectors++;
        if (flags !== F_REJ) begin
            miscompares++;
            $display("FAIL range_88_reject flags=%b required %b", flags, F_REJ);
        end
    endtask

    task automatic test_reject();
        logic [7:0] m2;
        my_color = 1'b1; turn = 1'b1;
        strobe(1'b1, 1'b0, 8'h00, 8'h00);
        exp_move = 8'h00;
        tick();
        tick();
        invalid_move = 1'b1;
        tick();
        invalid_move = 1'b0;
        vectors++;
        if (flags !== F_REJ || move !== 8'h00) begin
            miscompares++;
            $display("FAIL reject_pulse flags=%b move=%h required flags=%b move=00", flags, move, F_REJ);
        end
        m2 = rand_legal();
        strobe(1'b1, 1'b0, m2, 8'h00);
        exp_move = m2;
        vectors++;
        if (flags !== (F_AVAIL | F_BUSY) || move !== m2) begin
            miscompares++;
            $display("FAIL reject_reissue flags=%b move=%h required flags=%b move=%h",
                     flags, move, F_AVAIL | F_BUSY, m2);
        end
        tick();
        invalid_move = 1'b1;
        tick();
        invalid_move = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] m;
        for (int variant = 0; variant < 2; variant++) begin
            my_color = 1'b0; turn = 1'b0;
            m = rand_legal();
            strobe(1'b1, 1'b0, m, 8'h00);
            exp_move = m;
            for (int k = 0; k < TO; k++) begin
                tick();
                vectors++;
                if (flags !== F_BUSY) begin
                    miscompares++;
                    $display("FAIL timeout_wait v=%0d k=%0d flags=%b required %b", variant, k, flags, F_BUSY);
                end
            end
            if (variant == 1) turn = 1'b1;
            tick();
            vectors++;
            if (flags !== (variant == 1 ? F_ACC : F_TO) || move !== exp_move) begin
                miscompares++;
                $display("FAIL timeout_end v=%0d flags=%b move=%h required flags=%b move=%h",
                         variant, flags, move, variant == 1 ? F_ACC : F_TO, exp_move);
            end
            tick();
        end
        my_color = 1'b1; turn = 1'b1;
        strobe(1'b1, 1'b0, 8'h45, 8'h00);
        exp_move = 8'h45;
        tick();
        invalid_move = 1'b1;
        turn = 1'b0;
        tick();
        invalid_move = 1'b0;
        vectors++;
        if (flags !== F_REJ) begin
            miscompares++;
            $display("FAIL reject_priority flags=%b required %b", flags, F_REJ);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m, m2;
        my_color = 1'b0; turn = 1'b0;
        m = rand_legal();
        strobe(1'b1, 1'b0, m, 8'h00);
        exp_move = m;
        for (int k = 0; k < 5; k++) begin
            strobe(1'b1, 1'($urandom), rand_legal(), rand_illegal());
            vectors++;
            if (flags !== F_BUSY || move !== m) begin
                miscompares++;
                $display("FAIL busy_drop k=%0d flags=%b move=%h required flags=%b move=%h",
                         k, flags, move, F_BUSY, m);
            end
        end
        invalid_move = 1'b1;
        tick();
        invalid_move = 1'b0;
        m2 = rand_legal();
        strobe(1'b1, 1'b0, m2, 8'h00);
        exp_move = m2;
        vectors++;
        if (flags !== (F_AVAIL | F_BUSY) || move !== m2) begin
            miscompares++;
            $display("FAIL back_to_back flags=%b move=%h required flags=%b move=%h",
                     flags, move, F_AVAIL | F_BUSY, m2);
        end
        tick();
        turn = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_lock_and_reset();
        logic [7:0] m;
        // Reset in the middle of a pending move: no outcome may follow.
        my_color = 1'b0; turn = 1'b0;
        strobe(1'b1, 1'b0, 8'h12, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        turn = 1'b1;
        exp_move = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (flags !== 7'd0 || move !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_midop k=%0d flags=%b move=%h required flags=0000000 move=00", k, flags, move);
            end
        end
        my_color = 1'b1;
        m = rand_legal();
        strobe(1'b1, 1'b0, m, 8'h00);
        exp_move = m;
        tick();
        game_over = 1'b1;
        invalid_move = 1'b1;
        tick();
        invalid_move = 1'b0;
        vectors++;
        if (flags !== 7'd0 || move !== m) begin
            miscompares++;
            $display("FAIL lock_enter flags=%b move=%h required flags=0000000 move=%h", flags, move, m);
        end
        for (int k = 0; k < 8; k++) begin
            turn = 1'($urandom);
            game_over = 1'($urandom);
            invalid_move = 1'($urandom);
            strobe(1'b1, 1'b1, rand_legal(), rand_illegal());
            vectors++;
            if (flags !== 7'd0 || move !== m) begin
                miscompares++;
                $display("FAIL lock_ignore k=%0d flags=%b move=%h required flags=0000000 move=%h",
                         k, flags, move, m);
            end
        end
        invalid_move = 1'b0;
        game_over = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (flags !== 7'd0 || move !== 8'h00) begin
            miscompares++;
            $display("FAIL lock_reset flags=%b move=%h required flags=0000000 move=00", flags, move);
        end
        my_color = turn;
        strobe(1'b1, 1'b0, 8'h56, 8'h00);
        vectors++;
        if (flags !== (F_AVAIL | F_BUSY) || move !== 8'h56) begin
            miscompares++;
            $display("FAIL lock_reset_issue flags=%b move=%h required flags=%b move=56",
                     flags, move, F_AVAIL | F_BUSY);
        end
        // game_over on the same cycle as a legal strobe in IDLE: nothing issued.
        tick();
        invalid_move = 1'b1;
        tick();
        invalid_move = 1'b0;
        game_over = 1'b1;
        strobe(1'b1, 1'b1, 8'h77, 8'h99);
        vectors++;
        if (flags !== 7'd0 || move !== 8'h56) begin
            miscompares++;
            $display("FAIL lock_idle flags=%b move=%h required flags=0000000 move=56", flags, move);
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_wrong_src();
        test_range();
        test_reject();
        test_timeout();
        test_back_to_back();
        test_lock_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
